chan_mux_rr: RTL and testbench
==============================

// Module: chan_mux_rr
// PURPOSE
//  Parametrised N-channel, W-bit stream selector. Successor to the 4:1 combinational select.
//  Adds valid/ready handshakes, a registered output stage, and two modes:
//   - fixed select via sel
//   - round-robin arbitration across valid channels
//  Sits between several producer streams and one shared consumer (e.g. a UART TX or display path).
// PARAMETERS
//  NCH   4   number of input channels (>=2)
//  W     8   data width per channel
//  SELW  2   width of sel/out_ch; must equal $clog2(NCH)
// PORTS
//  clk        in   1         clock; all state updates on rising edge
//  rst_n      in   1         asynchronous active-low reset
//  mode       in   1         0 = fixed select, 1 = round-robin
//  sel        in   SELW      channel index used when mode=0
//  in_data    in   NCH*W     channel i occupies bits [i*W +: W]
//  in_valid   in   NCH       per-channel data valid
//  in_ready   out  NCH       per-channel accept; one-hot or zero
//  out_data   out  W         registered output data
//  out_valid  out  1         output register holds a word
//  out_ready  in   1         consumer accepts word this cycle
//  out_ch     out  SELW      channel index of word in output register
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
//   - in_ready=0 while reset is asserted.
//   - A word held in the output register is discarded; no partial transfer survives.
//  Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
//  free = !out_valid | out_ready. Loading on the same cycle as unloading is allowed, so full throughput is 1 word/clk.
//  Grant (combinational):
//   - mode=0: grant = sel if in_valid[sel]; otherwise no grant. Other channels are never granted.
//   - mode=1: grant = first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NCH.
//     No grant if all in_valid=0.
//  in_ready[g] = free & grant_valid for the granted channel g; all other bits are 0.
//   - in_ready must not depend on out_valid of the same word combinationally beyond free.
//  Transfer on channel g: in_valid[g] & in_ready[g]. Next edge: out_data<=in_data[g], out_ch<=g, out_valid<=1.
//  EMPTY->FULL on a transfer. FULL->EMPTY when out_ready & no transfer. FULL->FULL on load+unload, or on stall.
//  Stall (out_valid=1, out_ready=0): out_data and out_ch are held stable, and all in_ready=0.
//  Latency: 1 clk from input transfer to out_valid.
//  rr_ptr:
//   - Updates only on a transfer in mode=1: rr_ptr <= (g==NCH-1) ? 0 : g+1.
//   - Held in mode=0 and on idle cycles.
//  Mode or sel changes: take effect on the next grant evaluation. They never alter a word already in the output register.
//  rr_ptr is retained across mode switches.
//  Fairness: in mode=1 with all channels continuously valid and out_ready=1, channels are served 0,1,..,NCH-1,0,... with no gaps.
//  Protocol: producers hold in_data/in_valid until accepted. Behaviour is undefined if sel>=NCH when NCH is not a power of 2 (no grant is issued).
// TESTING
//  T1 reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately; in_ready=0.
//  T2 fixed mux (NCH=4, W=8):
//   - Stimulus: mode=0, sel=2, in_valid=4'b1111, data ch0..3=8'h10,8'h20,8'h30,8'h40, out_ready=1.
//   - Response: in_ready=4'b0100; out_data=8'h30, out_ch=2 one clk later.
//   - Then sel=1 -> next word 8'h20.
//  T3 round-robin:
//   - Stimulus: mode=1, all valid, out_ready=1 for 8 clks.
//   - Response: out_ch sequence 0,1,2,3,0,1,2,3; out_valid continuously 1 after the first clk.
//  T4 sparse round-robin:
//   - Stimulus: mode=1, in_valid=4'b1010, rr_ptr=0.
//   - Response: grants ch1, then ch3, then ch1, i.e. wrap-around skips idle channels.
//  T5 backpressure: out_ready=0 for 3 clks with word 8'hA5 loaded ->
//   - out_data=8'hA5 stable and in_ready=0 throughout.
//   - Then out_ready=1 -> word unloads and the next word loads the same cycle.
//  T6 mode switch:
//   - Stimulus: after a rr grant of ch2, set mode=0, sel=0 for 2 words, then mode=1.
//   - Response: the next rr grant starts at ch3.

Source files
------------

// File: rtl/chan_mux_rr_if.sv
// chan_mux_rr_if: producer-side and consumer-side stream signals of the channel selector
interface chan_mux_rr_if #(
  parameter int NCH = 4,
  parameter int W = 8,
  parameter int SELW = 2
);
  logic mode;
  logic [SELW-1:0] sel;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0] in_valid;
  logic [NCH-1:0] in_ready;
  logic [W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [SELW-1:0] out_ch;
  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input in_ready, out_data, out_valid, out_ch
  );
  modport slave (
    input mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ch
  );
endinterface

// File: rtl/chan_mux_rr.sv
// chan_mux_rr: N-channel stream selector with fixed or round-robin grant and a registered output
module chan_mux_rr #(
  parameter int NCH = 4,
  parameter int W = 8,
  parameter int SELW = 2
) (
  input logic clk,
  input logic rst_n,
  chan_mux_rr_if.slave bus
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  logic [0:0] state;
  logic [SELW-1:0] rr_ptr, g, out_ch;
  logic [W-1:0] out_data;
  logic gv, free, xfer;
  // grant: fixed channel when mode=0, first valid channel from rr_ptr when mode=1
  always_comb begin
    g = '0;
    gv = 1'b0;
    if (bus.mode) begin
      for (int k = NCH - 1; k >= 0; k--) begin
        if (bus.in_valid[(int'(rr_ptr) + k) % NCH]) begin
          g = SELW'((int'(rr_ptr) + k) % NCH);
          gv = 1'b1;
        end
      end
    end else if (int'(bus.sel) < NCH) begin
      g = bus.sel;
      gv = bus.in_valid[bus.sel];
    end
  end
  assign free = (state == EMPTY) | bus.out_ready;
  assign xfer = gv & free;
  assign bus.in_ready = (xfer & rst_n) ? NCH'(1) << g : '0;
  assign bus.out_valid = state == FULL;
  assign bus.out_data = out_data;
  assign bus.out_ch = out_ch;
  // output register load/unload and round-robin pointer advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      out_data <= '0;
      out_ch <= '0;
      rr_ptr <= '0;
    end else begin
      if (free) state <= xfer ? FULL : EMPTY;
      if (xfer) begin
        out_data <= bus.in_data[g*W +: W];
        out_ch <= g;
      end
      if (xfer & bus.mode) rr_ptr <= (int'(g) == NCH - 1) ? '0 : g + 1'b1;
    end
  end
endmodule

// File: tb/tb_chan_mux_rr.sv
// tb_chan_mux_rr: directed checks of fixed select, round-robin, backpressure, mode switch and reset
module tb_chan_mux_rr;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  chan_mux_rr_if #(.NCH(4), .W(8), .SELW(2)) bus ();
  chan_mux_rr #(.NCH(4), .W(8), .SELW(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    logic [1:0] sparse [3] = '{2'd1, 2'd3, 2'd1};
    bus.mode = 1'b0;
    bus.sel = 2'd2;
    bus.in_data = {8'h40, 8'h30, 8'h20, 8'h10};
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_ch", bus.out_ch, 0);
    chk("rst_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    #1 chk("fix_ready2", bus.in_ready, 4'b0100);
    @(negedge clk);
    chk("fix_data2", bus.out_data, 8'h30);
    chk("fix_ch2", bus.out_ch, 2);
    chk("fix_valid", bus.out_valid, 1);
    bus.sel = 2'd1;
    #1 chk("fix_ready1", bus.in_ready, 4'b0010);
    @(negedge clk);
    chk("fix_data1", bus.out_data, 8'h20);
    bus.mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_ch", bus.out_ch, i % 4);
      chk("rr_data", bus.out_data, (i % 4 + 1) * 16);
      chk("rr_valid", bus.out_valid, 1);
    end
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sparse_ch", bus.out_ch, sparse[i]);
    end
    bus.mode = 1'b0;
    bus.sel = 2'd0;
    bus.in_data[7:0] = 8'hA5;
    bus.in_valid = 4'b0001;
    @(negedge clk);
    chk("bp_load", bus.out_data, 8'hA5);
    bus.out_ready = 1'b0;
    bus.in_data[7:0] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("bp_data", bus.out_data, 8'hA5);
      chk("bp_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    #1 chk("bp_release_ready", bus.in_ready, 4'b0001);
    @(negedge clk);
    chk("bp_next", bus.out_data, 8'h5A);
    chk("bp_next_valid", bus.out_valid, 1);
    bus.in_data[7:0] = 8'h10;
    bus.mode = 1'b1;
    bus.in_valid = 4'b0100;
    @(negedge clk);
    chk("ms_rr2", bus.out_ch, 2);
    bus.mode = 1'b0;
    bus.sel = 2'd0;
    bus.in_valid = 4'b1111;
    @(negedge clk);
    chk("ms_fix0a", bus.out_ch, 0);
    @(negedge clk);
    chk("ms_fix0b", bus.out_ch, 0);
    bus.mode = 1'b1;
    @(negedge clk);
    chk("ms_rr3", bus.out_ch, 3);
    chk("ms_rr3_data", bus.out_data, 8'h40);
    @(negedge clk);
    chk("ms_rr0", bus.out_ch, 0);
    bus.in_valid = 4'b0000;
    @(negedge clk);
    chk("drain_valid", bus.out_valid, 0);
    bus.mode = 1'b0;
    bus.sel = 2'd3;
    bus.in_valid = 4'b1000;
    @(negedge clk);
    chk("pre_rst_valid", bus.out_valid, 1);
    chk("pre_rst_ch", bus.out_ch, 3);
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_data", bus.out_data, 0);
    chk("arst_ch", bus.out_ch, 0);
    chk("arst_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("arst_hold", bus.out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
